// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the core's memory-stage data port.
// Accepts one load/store over a valid/ready handshake and performs it on a
// byte-addressed, little-endian store. The response comes back LATENCY cycles
// after the accept edge. Stores commit on the accept edge.
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-high reset
//   req_valid / req_ready     request handshake
//   req_addr                  byte address (wraps modulo 2^ADDR_WIDTH)
//   req_we                    store byte enables, bit i -> req_addr+i
//   req_re                    load type: 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, else none
//   req_wdata                 store data
//   resp_valid / resp_ready   response handshake
//   resp_rdata                extended load data (0 for stores / no-ops)
//   resp_err                  misaligned-access flag
//   stall                     req_valid && !req_ready
//
// Build option: define DMEM_MISALIGN_TRAP_EN to detect misaligned accesses
// (blocked store, zero load data, resp_err=1). Without it, accesses wrap and
// resp_err stays 0.
//
// state  | meaning
// IDLE   | ready for a request
// WAIT   | counting wait states
// RESP   | response presented, held until resp_ready
module dmem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [3:0]            req_we,
  input  logic [2:0]            req_re,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  stall
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [2:0] RE_LB  = 3'd1;
  localparam logic [2:0] RE_LH  = 3'd2;
  localparam logic [2:0] RE_LW  = 3'd3;
  localparam logic [2:0] RE_LBU = 3'd4;
  localparam logic [2:0] RE_LHU = 3'd5;

  logic [1:0]            state;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] addrQ;
  logic [3:0]            weQ;
  logic [2:0]            reQ;

  logic [7:0] mem [0:(2**ADDR_WIDTH)-1];

  // In IDLE the live request is the one being accepted (matters for LATENCY=1);
  // afterwards the latched copy drives the read path.
  logic [ADDR_WIDTH-1:0] effAddr;
  logic [3:0]            effWe;
  logic [2:0]            effRe;
  logic [7:0]            rb [4];
  logic [31:0]           loadData;
  logic                  loadMis;
  logic                  storeMis;
  logic                  accept;

  assign accept     = (state == ST_IDLE) && req_valid;
  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign stall      = req_valid && !req_ready;

  assign effAddr = (state == ST_IDLE) ? req_addr : addrQ;
  assign effWe   = (state == ST_IDLE) ? req_we   : weQ;
  assign effRe   = (state == ST_IDLE) ? req_re   : reQ;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      rb[k] = mem[effAddr + ADDR_WIDTH'(k)];
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  always_comb begin
    loadMis  = 1'b0;
    storeMis = 1'b0;
    // A load riding along with a store is ignored, so it cannot misalign.
    if (effWe == 4'b0000) begin
      case (effRe)
        RE_LH, RE_LHU: loadMis = effAddr[0];
        RE_LW:         loadMis = |effAddr[1:0];
        default:       loadMis = 1'b0;
      endcase
    end
    if (effWe == 4'b0011 || effWe == 4'b1100) storeMis = effAddr[0];
    if (effWe == 4'b1111)                     storeMis = |effAddr[1:0];
  end
`else
  assign loadMis  = 1'b0;
  assign storeMis = 1'b0;
`endif

  always_comb begin
    loadData = 32'd0;
    if (effWe == 4'b0000 && !loadMis) begin
      case (effRe)
        RE_LB:   loadData = {{24{rb[0][7]}}, rb[0]};
        RE_LH:   loadData = {{16{rb[1][7]}}, rb[1], rb[0]};
        RE_LW:   loadData = {rb[3], rb[2], rb[1], rb[0]};
        RE_LBU:  loadData = {24'd0, rb[0]};
        RE_LHU:  loadData = {16'd0, rb[1], rb[0]};
        default: loadData = 32'd0;
      endcase
    end
  end

  // Storage is deliberately not reset; a store committed on the accept edge
  // survives a later reset.
  always_ff @(posedge clk) begin
    if (accept && !rst && !storeMis) begin
      for (int i = 0; i < 4; i++) begin
        if (req_we[i]) mem[req_addr + ADDR_WIDTH'(i)] <= req_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      addrQ      <= '0;
      weQ        <= 4'd0;
      reQ        <= 3'd0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            addrQ <= req_addr;
            weQ   <= req_we;
            reQ   <= req_re;
            cnt   <= 4'(LATENCY - 1);
            if (LATENCY == 1) begin
              state      <= ST_RESP;
              resp_rdata <= DATA_WIDTH'(loadData);
              resp_err   <= loadMis | storeMis;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state      <= ST_RESP;
            resp_rdata <= DATA_WIDTH'(loadData);
            resp_err   <= loadMis | storeMis;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            state      <= ST_IDLE;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  reqValid, reqReady, respValid, respReady, stallS, respErr;
  logic [7:0]  reqAddr   [3];
  logic [3:0]  reqWe     [3];
  logic [2:0]  reqRe     [3];
  logic [31:0] reqWdata  [3];
  logic [31:0] respRdata [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Instance 0: LATENCY=2, instance 1: LATENCY=1, instance 2: LATENCY=15.
  for (genvar g = 0; g < 3; g++) begin : gDut
    dmem_responder #(
      .ADDR_WIDTH(8),
      .DATA_WIDTH(32),
      .LATENCY(g == 0 ? 2 : (g == 1 ? 1 : 15))
    ) u (
      .clk(clk),
      .rst(rst),
      .req_valid(reqValid[g]),
      .req_ready(reqReady[g]),
      .req_addr(reqAddr[g]),
      .req_we(reqWe[g]),
      .req_re(reqRe[g]),
      .req_wdata(reqWdata[g]),
      .resp_valid(respValid[g]),
      .resp_ready(respReady[g]),
      .resp_rdata(respRdata[g]),
      .resp_err(respErr[g]),
      .stall(stallS[g])
    );
  end

  // Issue one request on instance k and collect its response.
  // lat = index of the first cycle after the accept edge with resp_valid high.
  task automatic do_req(input int k, input logic [7:0] a, input logic [3:0] we,
                        input logic [2:0] re, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    int n;
    @(negedge clk);
    reqAddr[k] = a; reqWe[k] = we; reqRe[k] = re; reqWdata[k] = wd;
    reqValid[k] = 1'b1;
    n = 0;
    while (!reqReady[k] && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1 reqValid[k] = 1'b0;
    @(negedge clk);
    lat = 1;
    while (!respValid[k] && lat < 40) begin @(negedge clk); lat++; end
    rd = respRdata[k];
    er = respErr[k];
    respReady[k] = 1'b1;
    @(posedge clk); #1 respReady[k] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    reqValid = '0; respReady = '0;
    for (int k = 0; k < 3; k++) begin
      reqAddr[k] = '0; reqWe[k] = '0; reqRe[k] = '0; reqWdata[k] = '0;
    end
    #23;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (reqReady[k] !== 1'b1 || respValid[k] !== 1'b0 || respRdata[k] !== 32'd0 ||
          respErr[k] !== 1'b0 || stallS[k] !== 1'b0)
        begin bad++; $display("FAIL reset_state inst%0d: ready=%b valid=%b rdata=%h err=%b stall=%b, want 1 0 0 0 0",
                              k, reqReady[k], respValid[k], respRdata[k], respErr[k], stallS[k]); end
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_store_load(input int k, input int L);
    logic [31:0] rd; logic er; int lat;
    logic [7:0]  ta [4] = '{8'h10, 8'h13, 8'h13, 8'h12};
    logic [2:0]  tr [4] = '{3'd3, 3'd1, 3'd4, 3'd2};
    logic [31:0] te [4] = '{32'hDEADBEEF, 32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD};
    do_req(k, 8'h10, 4'hF, 3'd0, 32'hDEADBEEF, rd, er, lat);
    total++;
    if (lat !== L) begin bad++; $display("FAIL store_latency L=%0d: got %0d want %0d", L, lat, L); end
    total++;
    if (rd !== 32'd0 || er !== 1'b0) begin bad++; $display("FAIL store_rdata L=%0d: got %h err=%b want 0 err=0", L, rd, er); end
    for (int i = 0; i < 4; i++) begin
      do_req(k, ta[i], 4'h0, tr[i], 32'd0, rd, er, lat);
      total++;
      if (rd !== te[i] || er !== 1'b0)
        begin bad++; $display("FAIL load_rdata L=%0d re=%0d addr=%h: got %h err=%b want %h err=0", L, tr[i], ta[i], rd, er, te[i]); end
      total++;
      if (lat !== L) begin bad++; $display("FAIL load_latency L=%0d re=%0d: got %0d want %0d", L, tr[i], lat, L); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int lat;
    @(negedge clk);
    reqAddr[0] = 8'h10; reqWe[0] = 4'h0; reqRe[0] = 3'd3; reqValid[0] = 1'b1;
    @(posedge clk); #1 reqValid[0] = 1'b0;
    @(negedge clk);
    lat = 1;
    while (!respValid[0] && lat < 40) begin @(negedge clk); lat++; end
    total++;
    if (respRdata[0] !== 32'hDEADBEEF || lat !== 2)
      begin bad++; $display("FAIL bp_first: rdata=%h lat=%0d want deadbeef lat=2", respRdata[0], lat); end
    // Queue the next request while the response is held.
    reqAddr[0] = 8'h10; reqRe[0] = 3'd5; reqValid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (respValid[0] !== 1'b1 || respRdata[0] !== 32'hDEADBEEF || stallS[0] !== 1'b1 || reqReady[0] !== 1'b0)
        begin bad++; $display("FAIL bp_hold cycle%0d: valid=%b rdata=%h stall=%b ready=%b want 1 deadbeef 1 0",
                              i, respValid[0], respRdata[0], stallS[0], reqReady[0]); end
    end
    respReady[0] = 1'b1;
    @(posedge clk); #1 respReady[0] = 1'b0;
    @(negedge clk);
    total++;
    if (reqReady[0] !== 1'b1 || respValid[0] !== 1'b0 || stallS[0] !== 1'b0)
      begin bad++; $display("FAIL bp_release: ready=%b valid=%b stall=%b want 1 0 0", reqReady[0], respValid[0], stallS[0]); end
    @(posedge clk); #1 reqValid[0] = 1'b0;
    total++;
    if (reqReady[0] !== 1'b0) begin bad++; $display("FAIL bp_accept: ready=%b want 0", reqReady[0]); end
    @(negedge clk);
    lat = 1;
    while (!respValid[0] && lat < 40) begin @(negedge clk); lat++; end
    rd = respRdata[0];
    respReady[0] = 1'b1;
    @(posedge clk); #1 respReady[0] = 1'b0;
    total++;
    if (rd !== 32'h0000BEEF || lat !== 2)
      begin bad++; $display("FAIL bp_second: rdata=%h lat=%0d want 0000beef lat=2", rd, lat); end
  endtask

  task automatic test_reset_midwait();
    logic [31:0] rd; logic er; int lat;
    @(negedge clk);
    reqAddr[2] = 8'h40; reqWe[2] = 4'hF; reqRe[2] = 3'd0; reqWdata[2] = 32'hCAFEF00D;
    reqValid[2] = 1'b1;
    @(posedge clk); #1 reqValid[2] = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (reqReady[2] !== 1'b0 || respValid[2] !== 1'b0)
      begin bad++; $display("FAIL midwait_state: ready=%b valid=%b want 0 0", reqReady[2], respValid[2]); end
    rst = 1'b1;
    #1;
    total++;
    if (reqReady[2] !== 1'b1 || respValid[2] !== 1'b0 || respRdata[2] !== 32'd0)
      begin bad++; $display("FAIL async_reset: ready=%b valid=%b rdata=%h want 1 0 0", reqReady[2], respValid[2], respRdata[2]); end
    @(negedge clk); rst = 1'b0;
    do_req(2, 8'h40, 4'h0, 3'd3, 32'd0, rd, er, lat);
    total++;
    if (rd !== 32'hCAFEF00D || lat !== 15)
      begin bad++; $display("FAIL after_reset_load: rdata=%h lat=%0d want cafef00d lat=15", rd, lat); end
  endtask

  task automatic test_conflict();
    logic [31:0] rd; logic er; int lat;
    do_req(1, 8'h20, 4'b0001, 3'd3, 32'h000000AB, rd, er, lat);
    total++;
    if (rd !== 32'd0 || lat !== 1) begin bad++; $display("FAIL conflict_rdata: got %h lat=%0d want 0 lat=1", rd, lat); end
    do_req(1, 8'h20, 4'h0, 3'd4, 32'd0, rd, er, lat);
    total++;
    if (rd !== 32'h000000AB) begin bad++; $display("FAIL conflict_byte: got %h want 000000ab", rd); end
    do_req(1, 8'h10, 4'h0, 3'd6, 32'd0, rd, er, lat);
    total++;
    if (rd !== 32'd0 || lat !== 1 || er !== 1'b0)
      begin bad++; $display("FAIL noop: rdata=%h lat=%0d err=%b want 0 1 0", rd, lat, er); end
    do_req(1, 8'h12, 4'h0, 3'd5, 32'd0, rd, er, lat);
    total++;
    if (rd !== 32'h0000DEAD) begin bad++; $display("FAIL lhu: got %h want 0000dead", rd); end
  endtask

`ifdef DMEM_MISALIGN_TRAP_EN
  task automatic test_misalign();
    logic [31:0] rd; logic er; int lat;
    do_req(0, 8'h06, 4'b0001, 3'd0, 32'h0000005A, rd, er, lat);
    total++;
    if (er !== 1'b0) begin bad++; $display("FAIL mis_byte_store_err: got %b want 0", er); end
    do_req(0, 8'h06, 4'hF, 3'd0, 32'hFFFFFFFF, rd, er, lat);
    total++;
    if (er !== 1'b1 || lat !== 2) begin bad++; $display("FAIL mis_store_err: err=%b lat=%0d want 1 2", er, lat); end
    do_req(0, 8'h06, 4'h0, 3'd4, 32'd0, rd, er, lat);
    total++;
    if (rd !== 32'h0000005A) begin bad++; $display("FAIL mis_store_blocked: got %h want 0000005a", rd); end
    do_req(0, 8'h05, 4'h0, 3'd3, 32'd0, rd, er, lat);
    total++;
    if (rd !== 32'd0 || er !== 1'b1) begin bad++; $display("FAIL mis_load: rdata=%h err=%b want 0 1", rd, er); end
  endtask
`else
  task automatic test_wrap();
    logic [31:0] rd; logic er; int lat;
    logic [7:0]  ta [4] = '{8'h00, 8'h01, 8'hFF, 8'hFE};
    logic [2:0]  tr [4] = '{3'd4, 3'd4, 3'd4, 3'd3};
    logic [31:0] te [4] = '{32'h22, 32'h11, 32'h33, 32'h11223344};
    do_req(0, 8'hFE, 4'hF, 3'd0, 32'h11223344, rd, er, lat);
    total++;
    if (er !== 1'b0 || rd !== 32'd0) begin bad++; $display("FAIL wrap_store: rdata=%h err=%b want 0 0", rd, er); end
    for (int i = 0; i < 4; i++) begin
      do_req(0, ta[i], 4'h0, tr[i], 32'd0, rd, er, lat);
      total++;
      if (rd !== te[i] || er !== 1'b0)
        begin bad++; $display("FAIL wrap_load addr=%h: got %h err=%b want %h err=0", ta[i], rd, er, te[i]); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_store_load(0, 2);
    test_store_load(1, 1);
    test_store_load(2, 15);
    test_backpressure();
    test_reset_midwait();
    test_conflict();
`ifdef DMEM_MISALIGN_TRAP_EN
    test_misalign();
`else
    test_wrap();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the core's memory-stage data port.
- Accepts load/store requests over a valid/ready handshake and performs them on a byte-addressed, little-endian store.
- Returns load data, sign- or zero-extended, after a programmable wait-state count.
- Replaces the single-cycle data store so the pipeline can be verified against variable-latency memory.

Parameters:
- ADDR_WIDTH, 8: byte-address width; storage is 2^ADDR_WIDTH bytes.
- DATA_WIDTH, 32: data word width; only 32 is supported.
- LATENCY, 2: cycles from request acceptance to resp_valid; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_addr  in  ADDR_WIDTH  byte address.
- req_we  in  4  store byte enables; bit i writes req_wdata byte i to req_addr+i.
- req_re  in  3  load type: 000 none, 001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU; 110 and 111 are treated as none.
- req_wdata  in  DATA_WIDTH  store data.
- resp_valid  out  1  response available.
- resp_ready  in  1  requester takes the response.
- resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and no-op requests.
- resp_err  out  1  misaligned access flag (see Optional Feature).
- stall  out  1  equals req_valid && !req_ready; drives the pipeline stall.

Behaviour:
- Clocking and reset: one clock, clk; reset is asynchronous and active-high, rst.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, counter=0. Storage contents are not reset.
- State IDLE:
  - req_ready=1.
  - A request is accepted when req_valid=1 at a clock edge.
  - Address, we, re and wdata are latched; counter is loaded with LATENCY-1.
  - If LATENCY=1, go to RESP; otherwise go to WAIT.
- Store commit: stores are written to storage on the acceptance edge. A load issued in the next request sees the written data.
- State WAIT:
  - req_ready=0.
  - Counter decrements each cycle; at counter==1 go to RESP on the next edge.
- Entering RESP:
  - resp_rdata and resp_err are registered on the edge entering RESP.
  - resp_valid=1 from the first cycle after that edge.
  - resp_valid is first high exactly LATENCY cycles after the accept edge.
- State RESP:
  - resp_valid, resp_rdata and resp_err are held stable until resp_ready=1.
  - On that edge: resp_valid goes to 0, state goes to IDLE, and req_ready=1 in the following cycle.
  - No back-to-back accept in the same edge.
- Load extension: LB and LH sign-extend from bit 7/15; LBU and LHU zero-fill. Byte k of a load is read from address (req_addr+k) mod 2^ADDR_WIDTH.
- Address wrap: accesses at top of memory wrap to 0 (e.g. LW at 0xFE reads 0xFE, 0xFF, 0x00, 0x01).
- Store with load: if req_we!=0 and req_re!=0, the store executes, the load is ignored, and resp_rdata=0.
- No-op request: req_we=0 and req_re none still completes the full handshake with resp_rdata=0.
- resp_ready outside RESP: ignored.
- Reset mid-operation: an in-flight request is abandoned and outputs return to reset values immediately. A store already committed on the accept edge remains in storage.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined — misaligned accesses are detected:
  - LH/LHU with addr[0]=1.
  - LW with addr[1:0]!=0.
  - req_we of 0011/1100 with addr[0]=1.
  - req_we of 1111 with addr[1:0]!=0.
  - A misaligned store does not write storage; a misaligned load returns resp_rdata=0.
  - resp_err=1 in the RESP cycles; the handshake timing is unchanged.
- Undefined: misaligned accesses complete with wrap addressing and resp_err is tied 0.

Test Plan:
- Reset, idle: assert rst mid-WAIT -> req_ready=1, resp_valid=0 asynchronously; deassert -> next request accepted normally.
- Store/load: LATENCY=2; store we=1111, wdata=0xDEADBEEF, addr 0x10; then LW 0x10 -> resp_valid first high 2 cycles after each accept; rdata=0xDEADBEEF. Then LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD.
- Backpressure: hold resp_ready=0 for 5 cycles -> resp_valid and resp_rdata stable; stall=1 while a new req_valid waits; accept occurs the cycle after resp_ready=1.
- Wrap: store 0x11223344 at 0xFE (misalign macro off) -> LBU 0x00=0x22, LBU 0x01=0x11, LBU 0xFF=0x33.
- Misalign (macro on): LW 0x05 -> resp_err=1, rdata=0. Store we=1111 at 0x06 -> memory at 0x06 unchanged, verified by LBU reads.
- Conflict and latency sweep: we=0001 with re=011 at 0x20, wdata=0xAB -> byte written, rdata=0. Repeat the store/load scenario with LATENCY=1 and LATENCY=15 -> resp_valid exactly 1 and 15 cycles after accept.
